// File: rtl/dmem_responder.sv
// Memory-side data-bus responder: one word load/store at a time, WAIT_CYCLES wait states, one-cycle DM_RDY pulse.
// Optional byte-lane writes when DMEM_BYTE_WRITE_EN is defined (adds input be[3:0]).
module dmem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        DM_CS,
  input  logic        DM_R,
  input  logic        DM_W,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
`ifdef DMEM_BYTE_WRITE_EN
  input  logic [3:0]  be,
`endif
  output logic [31:0] rdata,
  output logic        DM_RDY,
  output logic        DM_ERR,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        lat_r, lat_w;
  logic [31:0] lat_addr, lat_wdata;
  logic [31:0] mem [DEPTH];

  logic                  cur_r, cur_w;
  logic [31:0]           cur_addr, cur_wdata;
  logic [3:0]            cur_be;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  accept, go_resp, err, do_wr;

`ifdef DMEM_BYTE_WRITE_EN
  logic [3:0] lat_be;
`endif

  // With zero wait states the response edge is the acceptance edge, so the live bus is used there.
  always_comb begin
    cur_r     = (state == S_IDLE) ? DM_R  : lat_r;
    cur_w     = (state == S_IDLE) ? DM_W  : lat_w;
    cur_addr  = (state == S_IDLE) ? addr  : lat_addr;
    cur_wdata = (state == S_IDLE) ? wdata : lat_wdata;
`ifdef DMEM_BYTE_WRITE_EN
    cur_be    = (state == S_IDLE) ? be    : lat_be;
`else
    cur_be    = 4'hF;
`endif
    idx     = cur_addr[DEPTH_LOG2+1:2];
    accept  = (state == S_IDLE) && DM_CS;
    go_resp = (accept && (WAIT_CYCLES == 0)) || ((state == S_WAIT) && (cnt == 4'd0));
    err     = (cur_r | cur_w) &&
              ((|cur_addr[1:0]) || (|cur_addr[31:DEPTH_LOG2+2]) || (cur_r && cur_w));
    do_wr   = go_resp && cur_w && !cur_r && !err;
  end

  always_ff @(posedge clk) begin
    if (do_wr && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_be[i]) mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      rdata     <= 32'd0;
      DM_RDY    <= 1'b0;
      DM_ERR    <= 1'b0;
      busy      <= 1'b0;
      lat_r     <= 1'b0;
      lat_w     <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
`ifdef DMEM_BYTE_WRITE_EN
      lat_be    <= 4'd0;
`endif
    end else begin
      DM_RDY <= 1'b0;
      DM_ERR <= 1'b0;
      case (state)
        S_IDLE: begin
          if (DM_CS) begin
            lat_r     <= DM_R;
            lat_w     <= DM_W;
            lat_addr  <= addr;
            lat_wdata <= wdata;
`ifdef DMEM_BYTE_WRITE_EN
            lat_be    <= be;
`endif
            cnt <= CNT_INIT;
            if (WAIT_CYCLES == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              busy  <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state <= S_RESP;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (go_resp) begin
        DM_RDY <= 1'b1;
        DM_ERR <= err;
        if (err)        rdata <= 32'd0;
        else if (cur_r) rdata <= mem[idx];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, reset/zero-wait/byte-lane sequences, randomized traffic vs a word-array model.
module tb_dmem_responder;

  localparam int WC  = 2;
  localparam int LIM = WC + 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs, r, w, cs0, r0, w0;
  logic [31:0] addr, wdata, addr0, wdata0;
  logic [31:0] rdata, rdata0;
  logic        rdy, err, busy, rdy0, err0, busy0;
`ifdef DMEM_BYTE_WRITE_EN
  logic [3:0]  be, be0;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset), .DM_CS(cs), .DM_R(r), .DM_W(w), .addr(addr), .wdata(wdata),
`ifdef DMEM_BYTE_WRITE_EN
    .be(be),
`endif
    .rdata(rdata), .DM_RDY(rdy), .DM_ERR(err), .busy(busy)
  );

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .DM_CS(cs0), .DM_R(r0), .DM_W(w0), .addr(addr0), .wdata(wdata0),
`ifdef DMEM_BYTE_WRITE_EN
    .be(be0),
`endif
    .rdata(rdata0), .DM_RDY(rdy0), .DM_ERR(err0), .busy(busy0)
  );

  // Reference model: word array with per-byte "written" flags, plus the last read response.
  logic [31:0] mmem [1024];
  bit   [3:0]  mval [1024];
  logic [31:0] m_rdata;
  bit          m_rknown;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_step(input bit mr, input bit mw, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] bev, output bit e_err, output logic [31:0] e_rd,
                            output bit known);
    int unsigned wi;
    logic [3:0] bm;
`ifdef DMEM_BYTE_WRITE_EN
    bm = bev;
`else
    bm = 4'hF;
`endif
    wi = a / 4;
    e_err = (mr || mw) && ((a % 4) != 0 || a >= 32'h1000 || (mr && mw));
    if (e_err) begin
      m_rdata  = 32'd0;
      m_rknown = 1'b1;
    end else if (mr) begin
      m_rdata  = mmem[wi];
      m_rknown = (mval[wi] == 4'hF);
    end else if (mw) begin
      for (int i = 0; i < 4; i++) begin
        if (bm[i]) begin
          mmem[wi][8*i +: 8] = d[8*i +: 8];
          mval[wi][i] = 1'b1;
        end
      end
    end
    e_rd  = m_rdata;
    known = m_rknown;
  endtask

  // Called #1 after a rising edge with the DUT idle; returns the response seen with DM_RDY.
  task automatic run_txn(input bit tr, input bit tw, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] bev, output logic [31:0] o_rd, output logic o_err);
    int lat = -1;
    int k = 1;
    cs = 1'b1; r = tr; w = tw; addr = a; wdata = d;
`ifdef DMEM_BYTE_WRITE_EN
    be = bev;
`endif
    o_rd = 32'hx; o_err = 1'bx;
    @(posedge clk); #1;
    while (lat < 0 && k <= LIM) begin
      if (rdy) begin
        lat = k;
        o_rd = rdata;
        o_err = err;
        chk("busy_low_at_rdy", {31'd0, busy}, 32'd0);
      end else begin
        chk("busy_during_wait", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        k++;
      end
    end
    cs = 1'b0; r = 1'b0; w = 1'b0;
    chk("latency", 32'(lat), 32'(WC + 1));
    if (lat > 0) begin
      @(posedge clk); #1;
      chk("rdy_one_cycle", {31'd0, rdy}, 32'd0);
      chk("rdata_hold", rdata, o_rd);
    end
  endtask

  typedef struct {
    bit          r, w;
    logic [31:0] a, d;
    logic [3:0]  be;
    bit          e_err;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [31:0] g_rd, e_rd;
    logic        g_err;
    bit          e_err, known;

    tbl[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0000_0000};
    tbl[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b0, 1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'hDEAD_BEEF};
    tbl[3]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         4'hF, 1'b1, 32'h0000_0000};
    tbl[4]  = '{1'b1, 1'b0, 32'h0000_0006, 32'h0,         4'hF, 1'b1, 32'h0000_0000};
    tbl[5]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         4'hF, 1'b0, 32'hA5A5_A5A5};
    tbl[6]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 4'hF, 1'b0, 32'hA5A5_A5A5};
    tbl[7]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF, 1'b1, 32'h0000_0000};
    tbl[8]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         4'hF, 1'b0, 32'h0BAD_F00D};
    tbl[9]  = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,         4'hF, 1'b0, 32'h0BAD_F00D};
    tbl[10] = '{1'b0, 1'b1, 32'h0000_0042, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0000_0000};
    tbl[11] = '{1'b0, 1'b1, 32'h0000_0040, 32'h1111_1111, 4'hF, 1'b0, 32'h0000_0000};
    tbl[12] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         4'hF, 1'b0, 32'h1111_1111};
    tbl[13] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0,         4'hF, 1'b1, 32'h0000_0000};
    tbl[14] = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h7766_5544, 4'hF, 1'b0, 32'h0000_0000};
    tbl[15] = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         4'hF, 1'b0, 32'h7766_5544};

    m_rdata = 32'd0; m_rknown = 1'b1;
    reset = 1'b1;
    cs = 0; r = 0; w = 0; addr = 0; wdata = 0;
    cs0 = 0; r0 = 0; w0 = 0; addr0 = 0; wdata0 = 0;
`ifdef DMEM_BYTE_WRITE_EN
    be = 4'hF; be0 = 4'hF;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_rdy", {31'd0, rdy}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      model_step(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].be, e_err, e_rd, known);
      run_txn(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].be, g_rd, g_err);
      chk($sformatf("vec%0d_err", i), {31'd0, g_err}, {31'd0, tbl[i].e_err});
      chk($sformatf("vec%0d_rdata", i), g_rd, tbl[i].e_rd);
    end

    // Reset during WAIT aborts a write to 0x40 (holding 0x11111111).
    cs = 1; w = 1; r = 0; addr = 32'h40; wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_rst_busy", {31'd0, busy}, 32'd0);
    chk("abort_rst_rdy", {31'd0, rdy}, 32'd0);
    chk("abort_rst_rdata", rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_rst_rdy_held", {31'd0, rdy}, 32'd0);
    chk("abort_rst_err_held", {31'd0, err}, 32'd0);
    cs = 0; w = 0;
    reset = 1'b0;
    m_rdata = 32'd0; m_rknown = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("abort_no_rdy", {31'd0, rdy}, 32'd0);
    end
    model_step(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, e_err, e_rd, known);
    run_txn(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, g_rd, g_err);
    chk("abort_read_old", g_rd, 32'h1111_1111);
    chk("abort_read_err", {31'd0, g_err}, 32'd0);

    // Zero wait states: write, then hold a read request; DM_RDY every second cycle.
    cs0 = 1; w0 = 1; r0 = 0; addr0 = 32'h10; wdata0 = 32'h5A5A_0001;
    @(posedge clk); #1;
    chk("w0_rdy", {31'd0, rdy0}, 32'd1);
    chk("w0_err", {31'd0, err0}, 32'd0);
    chk("w0_busy", {31'd0, busy0}, 32'd0);
    w0 = 0; r0 = 1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("w0_pulse%0d", k), {31'd0, rdy0}, {31'd0, (k % 2) == 0});
      chk("w0_busy_low", {31'd0, busy0}, 32'd0);
      if ((k % 2) == 0) chk("w0_rdata", rdata0, 32'h5A5A_0001);
    end
    cs0 = 0; r0 = 0;
    @(posedge clk); #1;

`ifdef DMEM_BYTE_WRITE_EN
    model_step(1'b0, 1'b1, 32'h80, 32'h1122_3344, 4'b1111, e_err, e_rd, known);
    run_txn(1'b0, 1'b1, 32'h80, 32'h1122_3344, 4'b1111, g_rd, g_err);
    model_step(1'b0, 1'b1, 32'h80, 32'hAABB_CCDD, 4'b0101, e_err, e_rd, known);
    run_txn(1'b0, 1'b1, 32'h80, 32'hAABB_CCDD, 4'b0101, g_rd, g_err);
    model_step(1'b0, 1'b1, 32'h80, 32'h9999_9999, 4'b0000, e_err, e_rd, known);
    run_txn(1'b0, 1'b1, 32'h80, 32'h9999_9999, 4'b0000, g_rd, g_err);
    chk("be_zero_err", {31'd0, g_err}, 32'd0);
    model_step(1'b1, 1'b0, 32'h80, 32'h0, 4'b0000, e_err, e_rd, known);
    run_txn(1'b1, 1'b0, 32'h80, 32'h0, 4'b0000, g_rd, g_err);
    chk("be_merge", g_rd, 32'h11BB_33DD);
`endif

    for (int n = 0; n < 200; n++) begin
      bit          tr, tw;
      logic [31:0] a, d;
      logic [3:0]  bev;
      int          kind;
      kind = $urandom_range(0, 9);
      d    = $urandom;
      a    = $urandom_range(0, 63) * 4;
      tr   = 0; tw = 0;
`ifdef DMEM_BYTE_WRITE_EN
      bev = 4'($urandom_range(0, 15));
`else
      bev = 4'hF;
`endif
      case (kind)
        0, 1, 2, 3: tw = 1;
        4, 5, 6:    tr = 1;
        7:          ;
        8: begin
          tr = $urandom_range(0, 1);
          tw = !tr;
          case ($urandom_range(0, 2))
            0:       a = a | 32'($urandom_range(1, 3));
            1:       a = a | (32'h1000 << $urandom_range(0, 19));
            default: begin tr = 1; tw = 1; end
          endcase
        end
        default: begin tr = 1; a = $urandom_range(0, 1023) * 4; end
      endcase
      model_step(tr, tw, a, d, bev, e_err, e_rd, known);
      run_txn(tr, tw, a, d, bev, g_rd, g_err);
      chk($sformatf("rnd%0d_err a=%h", n, a), {31'd0, g_err}, {31'd0, e_err});
      if (known) chk($sformatf("rnd%0d_rdata a=%h", n, a), g_rd, e_rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
